// File: rtl/alu_pkg.sv
// Package for the serial ALU: opcode encodings and the controller state type.
// Shared by alu_serial (top) and alu_slice (ripple slice).
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

endpackage

// File: rtl/alu_slice.sv
// Combinational DIGIT-bit ripple slice of the serial ALU.
// Ports:
//   a, b  : DIGIT-bit operand digits
//   cin   : carry into the least-significant bit of the digit
//   op    : opcode (ADD/SUB/AND/OR); SUB inverts b internally
//   sum   : DIGIT-bit result digit
//   cout  : carry out of the digit (0 for AND/OR)
module alu_slice
   import alu_pkg::*;
#(
   parameter int unsigned DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   input  logic [1:0]       op,
   output logic [DIGIT-1:0] sum,
   output logic             cout
);

   logic             c;
   logic [DIGIT-1:0] b_eff;

   always_comb begin
      c     = cin;
      sum   = '0;
      cout  = 1'b0;
      b_eff = (op == OP_SUB) ? ~b : b;
      unique case (op)
         OP_AND: sum = a & b;
         OP_OR:  sum = a | b;
         default: begin
            // ADD and SUB share the ripple chain; SUB gets cin=1 on the first digit
            for (int i = 0; i < int'(DIGIT); i++) begin
               sum[i] = a[i] ^ b_eff[i] ^ c;
               c      = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
            end
            cout = c;
         end
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU (ADD, SUB, AND, OR) with valid/ready handshakes.
// A request is captured in IDLE, processed DIGIT bits per cycle over WIDTH/DIGIT
// BUSY cycles through one alu_slice, then held in DONE until out_ready.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : request handshake carrying a, b, op
//   out_valid / out_ready: result handshake carrying result, carry_out
//   carry_out            : adder carry (SUB: 1 = no borrow), 0 for AND/OR
// Optional macro ALU_SERIAL_FLAGS_EN adds zero, negative and overflow outputs,
// valid only while out_valid is high and 0 otherwise.
module alu_serial
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
`ifdef ALU_SERIAL_FLAGS_EN
   ,
   output logic             zero,
   output logic             negative,
   output logic             overflow
`endif
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("alu_serial: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [1:0]       op_q, op_d;
   logic             carry_q, carry_d;
   logic [DIGIT-1:0] slice_sum;
   logic             slice_cout;
   logic             last_digit;

   alu_slice #(
      .DIGIT (DIGIT)
   ) u_slice (
      .a    (a_q[DIGIT-1:0]),
      .b    (b_q[DIGIT-1:0]),
      .cin  (carry_q),
      .op   (op_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   assign last_digit = (cnt_q == CW'(NDIG - 1));

`ifdef ALU_SERIAL_FLAGS_EN
   logic ovf_q, ovf_d;
   logic b_msb_eff;

   // On the last digit the slice sees the operand MSBs, so signed overflow is
   // "operands agree in sign, result sign differs".
   assign b_msb_eff = b_q[DIGIT-1] ^ (op_q == OP_SUB);

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == StBusy && last_digit) begin
         ovf_d = !op_q[1] && (a_q[DIGIT-1] == b_msb_eff) &&
                 (slice_sum[DIGIT-1] != a_q[DIGIT-1]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign zero     = out_valid && (res_q == '0);
   assign negative = out_valid && res_q[WIDTH-1];
   assign overflow = out_valid && ovf_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      op_d    = op_q;
      carry_d = carry_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               carry_d = (op == OP_SUB);
               cnt_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            // Operands shift right; result digits enter from the top
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = (res_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
            carry_d = slice_cout;
            cnt_d   = cnt_q + CW'(1);
            if (last_digit) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         op_q    <= OP_ADD;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         op_q    <= op_d;
         carry_q <= carry_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = res_q;
   assign carry_out = carry_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed self-checking bench for alu_serial (WIDTH=8 with DIGIT=1 and DIGIT=4).
module tb_alu_serial;
   import alu_pkg::*;

   logic       clk;
   logic       rst_n;
   // DIGIT=1 instance
   logic       in_valid, in_ready, out_valid, out_ready, carry_out;
   logic [7:0] a, b, result;
   logic [1:0] op;
   // DIGIT=4 instance
   logic       in_valid4, in_ready4, out_valid4, out_ready4, carry_out4;
   logic [7:0] a4, b4, result4;
   logic [1:0] op4;
`ifdef ALU_SERIAL_FLAGS_EN
   logic       zero, negative, overflow;
   logic       zero4, negative4, overflow4;
`endif

   int passed = 0;
   int total  = 0;

   alu_serial #(.WIDTH(8), .DIGIT(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out)
`ifdef ALU_SERIAL_FLAGS_EN
      ,
      .zero      (zero),
      .negative  (negative),
      .overflow  (overflow)
`endif
   );

   alu_serial #(.WIDTH(8), .DIGIT(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .a         (a4),
      .b         (b4),
      .op        (op4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .result    (result4),
      .carry_out (carry_out4)
`ifdef ALU_SERIAL_FLAGS_EN
      ,
      .zero      (zero4),
      .negative  (negative4),
      .overflow  (overflow4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one request on the DIGIT=1 instance; returns just after the
   // acceptance edge with the inputs scrambled.
   task automatic start(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop);
      @(negedge clk);
      in_valid = 1'b1;
      a = ia;
      b = ib;
      op = iop;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      op = 2'($urandom);
   endtask

   // Count rising edges until out_valid, bounded at 40.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_hs got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
      else passed++;
      total++;
      if (result !== 8'h00 || carry_out !== 1'b0) $display("FAIL reset_data got result=%h carry=%b expected 00/0", result, carry_out);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_release got ready=%b valid=%b expected 1/0", in_ready, out_valid);
      else passed++;
   endtask

   task automatic test_add();
      int cyc;
      start(8'hFF, 8'h01, OP_ADD);
      wait_done(cyc);
      total++;
      if (cyc !== 8) $display("FAIL add_latency got %0d expected 8", cyc);
      else passed++;
      total++;
      if (result !== 8'h00 || carry_out !== 1'b1) $display("FAIL add_ff_01 got %h/%b expected 00/1", result, carry_out);
      else passed++;
`ifdef ALU_SERIAL_FLAGS_EN
      total++;
      if (zero !== 1'b1) $display("FAIL add_zero got %b expected 1", zero);
      else passed++;
`endif
      consume();
      start(8'h7F, 8'h01, OP_ADD);
      wait_done(cyc);
      total++;
      if (result !== 8'h80 || carry_out !== 1'b0) $display("FAIL add_7f_01 got %h/%b expected 80/0", result, carry_out);
      else passed++;
`ifdef ALU_SERIAL_FLAGS_EN
      total++;
      if (overflow !== 1'b1 || negative !== 1'b1) $display("FAIL add_ovf got ovf=%b neg=%b expected 1/1", overflow, negative);
      else passed++;
`endif
      consume();
   endtask

   task automatic test_sub();
      int cyc;
      start(8'h05, 8'h07, OP_SUB);
      wait_done(cyc);
      total++;
      if (result !== 8'hFE || carry_out !== 1'b0) $display("FAIL sub_05_07 got %h/%b expected FE/0", result, carry_out);
      else passed++;
`ifdef ALU_SERIAL_FLAGS_EN
      total++;
      if (negative !== 1'b1 || overflow !== 1'b0) $display("FAIL sub_neg got neg=%b ovf=%b expected 1/0", negative, overflow);
      else passed++;
`endif
      consume();
      start(8'h07, 8'h05, OP_SUB);
      wait_done(cyc);
      total++;
      if (result !== 8'h02 || carry_out !== 1'b1) $display("FAIL sub_07_05 got %h/%b expected 02/1", result, carry_out);
      else passed++;
      consume();
   endtask

   task automatic test_logic();
      int cyc;
      start(8'hF0, 8'h3C, OP_AND);
      wait_done(cyc);
      total++;
      if (result !== 8'h30 || carry_out !== 1'b0) $display("FAIL and got %h/%b expected 30/0", result, carry_out);
      else passed++;
      consume();
      start(8'hF0, 8'h3C, OP_OR);
      wait_done(cyc);
      total++;
      if (result !== 8'hFC || carry_out !== 1'b0) $display("FAIL or got %h/%b expected FC/0", result, carry_out);
      else passed++;
`ifdef ALU_SERIAL_FLAGS_EN
      total++;
      if (overflow !== 1'b0 || negative !== 1'b1) $display("FAIL or_flags got ovf=%b neg=%b expected 0/1", overflow, negative);
      else passed++;
`endif
      consume();
   endtask

   task automatic test_backpressure();
      int cyc;
      start(8'h55, 8'h0A, OP_ADD);
      wait_done(cyc);
      @(negedge clk);
      in_valid = 1'b1;
      a = 8'h01;
      b = 8'h01;
      op = OP_SUB;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h5F || carry_out !== 1'b0)
            $display("FAIL hold_%0d got valid=%b ready=%b result=%h carry=%b expected 1/0/5F/0", i, out_valid, in_ready, result, carry_out);
         else passed++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      consume();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL hold_release got ready=%b valid=%b expected 1/0", in_ready, out_valid);
      else passed++;
      repeat (10) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL hold_ignored got valid=%b ready=%b expected 0/1", out_valid, in_ready);
      else passed++;
   endtask

   task automatic test_reset_busy();
      int cyc;
      start(8'hAA, 8'h11, OP_ADD);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL abort_async got valid=%b ready=%b expected 0/1", out_valid, in_ready);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'h00) $display("FAIL abort_no_result got valid=%b ready=%b result=%h expected 0/1/00", out_valid, in_ready, result);
      else passed++;
      start(8'h12, 8'h34, OP_ADD);
      wait_done(cyc);
      total++;
      if (cyc !== 8 || result !== 8'h46) $display("FAIL after_abort got cyc=%0d result=%h expected 8/46", cyc, result);
      else passed++;
      consume();
   endtask

   task automatic test_digit4();
      int cyc;
      @(negedge clk);
      in_valid4 = 1'b1;
      a4 = 8'h8F;
      b4 = 8'h71;
      op4 = OP_ADD;
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      a4 = 8'h00;
      b4 = 8'h00;
      cyc = 0;
      while (out_valid4 !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      total++;
      if (cyc !== 2) $display("FAIL d4_latency got %0d expected 2", cyc);
      else passed++;
      total++;
      if (result4 !== 8'h00 || carry_out4 !== 1'b1) $display("FAIL d4_add got %h/%b expected 00/1", result4, carry_out4);
      else passed++;
      @(negedge clk);
      out_ready4 = 1'b1;
      @(posedge clk);
      #1;
      out_ready4 = 1'b0;
      total++;
      if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) $display("FAIL d4_release got ready=%b valid=%b expected 1/0", in_ready4, out_valid4);
      else passed++;
   endtask

   initial begin
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      op = OP_ADD;
      in_valid4 = 1'b0;
      out_ready4 = 1'b0;
      a4 = '0;
      b4 = '0;
      op4 = OP_ADD;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_backpressure();
      test_reset_busy();
      test_digit4();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>= 2).
REQ-002 SHALL have parameter DIGIT, default 1, bits processed per cycle; WIDTH % DIGIT != 0 SHALL be an elaboration error.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  operation result.
REQ-013 SHALL have port carry_out  output  1  adder carry; SUB: 1 = no borrow; 0 for AND/OR.

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-015 IDLE: in_ready=1; in_valid&in_ready SHALL capture a, b, op and enter BUSY; carry register initialised to 1 for SUB, 0 otherwise.
REQ-016 BUSY: each cycle SHALL process the DIGIT least-significant unprocessed bits; SUB uses ~b; carry register chains between cycles.
REQ-017 BUSY SHALL last exactly WIDTH/DIGIT cycles; out_valid SHALL rise on the first edge after the last digit, i.e. WIDTH/DIGIT cycles after acceptance edge.
REQ-018 DONE: out_valid=1, in_ready=0; result, carry_out and flags SHALL hold stable until out_valid&out_ready, then return to IDLE.
REQ-019 in_ready SHALL be 0 in BUSY and DONE; in_valid there SHALL be ignored; no request overlap.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH; carry_out = bit WIDTH of a + (b or ~b) + cin.
REQ-021 AND/OR SHALL be bitwise on captured operands; carry_out=0.
REQ-022 Input changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, result=0, carry_out=0, flags=0, counter and carry register 0.
REQ-024 Reset during BUSY or DONE SHALL abort the operation with no result presented.

Configuration
REQ-025 Macro ALU_SERIAL_FLAGS_EN defined: SHALL add outputs zero (result==0), negative (result[WIDTH-1]), overflow (signed overflow for ADD/SUB, 0 for AND/OR), valid with out_valid, 0 otherwise.
REQ-026 Macro undefined: flag ports and flag logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package alu_pkg SHALL hold opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR) and FSM state typedef.
REQ-028 Sub-module alu_slice SHALL be the combinational DIGIT-bit ripple slice (a, b, cin, op -> sum, cout), instantiated once.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-029 ADD 0xFF+0x01 -> result 0x00, carry_out 1, zero 1, out_valid exactly 8 cycles after acceptance.
REQ-030 SUB 0x05-0x07 -> result 0xFE, carry_out 0, negative 1; SUB 0x07-0x05 -> 0x02, carry_out 1.
REQ-031 AND 0xF0,0x3C -> 0x30, carry_out 0; OR same -> 0xFC; ADD 0x7F+0x01 -> 0x80, overflow 1.
REQ-032 out_ready held low 3 cycles in DONE -> result/flags stable, in_ready 0, concurrent in_valid ignored; then returns to IDLE.
REQ-033 rst_n pulsed low in 4th BUSY cycle -> out_valid 0, in_ready 1 after release; next ADD 0x12+0x34 -> 0x46.
REQ-034 DIGIT=4: ADD 0x8F+0x71 -> 0x00, carry_out 1, out_valid 2 cycles after acceptance.
